// File: rtl/lsu_if.sv
// lsu_if: bundles the EXU->LSU operation link, the LSU->WBU write-back link
// and the LSU memory request/response port.
// The slave modport is the LSU side. The master modport is the surrounding pipeline/memory side.
interface lsu_if;
    logic         exu_valid;
    logic [108:0] exu_data;
    logic         lsu_ready;
    logic         lsu_valid;
    logic [37:0]  lsu_data;
    logic         lsu_fault;
    logic         wbu_ready;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_wen;
    logic [31:0]  mem_req_addr;
    logic [31:0]  mem_req_wdata;
    logic [3:0]   mem_req_wstrb;
    logic         mem_resp_valid;
    logic [31:0]  mem_resp_rdata;
    logic         mem_resp_ready;

    modport slave (
        input  exu_valid, exu_data, wbu_ready, mem_req_ready,
               mem_resp_valid, mem_resp_rdata,
        output lsu_ready, lsu_valid, lsu_data, lsu_fault,
               mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
               mem_req_wstrb, mem_resp_ready
    );

    modport master (
        output exu_valid, exu_data, wbu_ready, mem_req_ready,
               mem_resp_valid, mem_resp_rdata,
        input  lsu_ready, lsu_valid, lsu_data, lsu_fault,
               mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
               mem_req_wstrb, mem_resp_ready
    );
endinterface

// File: rtl/lsu.sv
// lsu: load/store unit of the multi-cycle NPC core.
// It accepts one packed operation from EXU and performs at most one memory access.
// It then holds the write-back bundle until WBU accepts it.
// Optional feature: define LSU_MISALIGN_CHECK_EN to turn misaligned halfword and word
// accesses into a fault bundle with no memory request.
module lsu #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave lsu_bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_OUT       = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Byte-lane enables for a store: byte and half shift into place, word covers all lanes.
    function automatic logic [3:0] f_store_strb(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] lanes;
        case (funct3[1:0])
            2'b00:   lanes = 4'b0001 << off;
            2'b01:   lanes = 4'b0011 << off;
            default: lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

    // Align the loaded word to bit 0, then sign- or zero-extend it per funct3.
    function automatic logic [31:0] f_load_ext(input logic [31:0] rdata, input logic [1:0] off,
                                               input logic [2:0] funct3);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {off, 3'b000};
        case (funct3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b100:  res = {24'h000000, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b101:  res = {16'h0000, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    // Halfword accesses need an even address. Word accesses need a 4-byte aligned address.
    function automatic logic f_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic half;
        logic word;
        half = (funct3[1:0] == 2'b01);
        word = (funct3 == 3'b010);
        return (half & off[0]) | (word & (off != 2'b00));
    endfunction
`endif

    // Field decode of the offered operation
    logic [WIDTH-1:0] w_in_addr;
    logic             w_in_ren;
    logic             w_in_wen;
    logic [2:0]       w_in_funct3;
    logic [WIDTH-1:0] w_in_store_data;
    logic [4:0]       w_in_rd;
    logic             w_in_reg_wen;
    logic [1:0]       w_in_wb_sel;
    logic [WIDTH-1:0] w_in_csr_data;
    logic             w_in_mem_op;
    logic             w_in_misaligned;
    logic             w_accept;

    assign w_in_addr       = lsu_bus.exu_data[108:77];
    assign w_in_ren        = lsu_bus.exu_data[76];
    assign w_in_wen        = lsu_bus.exu_data[75];
    assign w_in_funct3     = lsu_bus.exu_data[74:72];
    assign w_in_store_data = lsu_bus.exu_data[71:40];
    assign w_in_rd         = lsu_bus.exu_data[39:35];
    assign w_in_reg_wen    = lsu_bus.exu_data[34];
    assign w_in_wb_sel     = lsu_bus.exu_data[33:32];
    assign w_in_csr_data   = lsu_bus.exu_data[31:0];
    assign w_in_mem_op     = w_in_ren | w_in_wen;
`ifdef LSU_MISALIGN_CHECK_EN
    assign w_in_misaligned = w_in_mem_op & f_misaligned(w_in_funct3, w_in_addr[1:0]);
`else
    assign w_in_misaligned = 1'b0;
`endif
    assign w_accept        = lsu_bus.exu_valid & (r_state == S_IDLE);

    // Latched operation and write-back bundle
    logic [WIDTH-1:0] r_addr;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [WIDTH-1:0] r_req_wdata;
    logic [3:0]       r_req_wstrb;
    logic [4:0]       r_rd;
    logic             r_reg_wen;
    logic [WIDTH-1:0] r_wb_data;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic. The S_REQ exit depends only on mem_req_ready and never feeds back into mem_req_*.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (lsu_bus.exu_valid) begin
                    if (w_in_mem_op & ~w_in_misaligned) begin
                        w_state_next = S_REQ;
                    end else begin
                        w_state_next = S_OUT;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (lsu_bus.mem_req_ready) begin
                    w_state_next = S_WAIT_RESP;
                end else begin
                    w_state_next = S_REQ;
                end
            end
            S_WAIT_RESP: begin
                if (lsu_bus.mem_resp_valid) begin
                    w_state_next = S_OUT;
                end else begin
                    w_state_next = S_WAIT_RESP;
                end
            end
            S_OUT: begin
                if (lsu_bus.wbu_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_OUT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Capture the operation on acceptance, and the extended load data on the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= 32'h0000_0000;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_req_wdata <= 32'h0000_0000;
            r_req_wstrb <= 4'b0000;
            r_rd        <= 5'd0;
            r_reg_wen   <= 1'b0;
            r_wb_data   <= 32'h0000_0000;
        end else if (w_accept) begin
            r_addr      <= w_in_addr;
            r_is_store  <= w_in_wen;
            r_funct3    <= w_in_funct3;
            r_req_wdata <= w_in_store_data << {w_in_addr[1:0], 3'b000};
            r_req_wstrb <= w_in_wen ? f_store_strb(w_in_funct3, w_in_addr[1:0]) : 4'b0000;
            r_rd        <= w_in_rd;
            // Stores and faulting accesses never write the register file
            r_reg_wen   <= w_in_reg_wen & ~w_in_wen & ~w_in_misaligned;
            if (w_in_mem_op) begin
                r_wb_data <= 32'h0000_0000;
            end else begin
                case (w_in_wb_sel)
                    2'b00:   r_wb_data <= w_in_addr;
                    2'b10:   r_wb_data <= w_in_csr_data;
                    default: r_wb_data <= 32'h0000_0000;
                endcase
            end
        end else if ((r_state == S_WAIT_RESP) && lsu_bus.mem_resp_valid && !r_is_store) begin
            r_wb_data <= f_load_ext(lsu_bus.mem_resp_rdata, r_addr[1:0], r_funct3);
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic r_fault;

    // Fault flag for the operation currently held, refreshed on every acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_fault <= w_in_misaligned;
        end
    end

    assign lsu_bus.lsu_fault = r_fault & (r_state == S_OUT);
`else
    assign lsu_bus.lsu_fault = 1'b0;
`endif

    assign lsu_bus.lsu_ready      = (r_state == S_IDLE);
    assign lsu_bus.lsu_valid      = (r_state == S_OUT);
    assign lsu_bus.lsu_data       = {r_rd, r_reg_wen, r_wb_data};
    assign lsu_bus.mem_req_valid  = (r_state == S_REQ);
    assign lsu_bus.mem_req_wen    = r_is_store;
    assign lsu_bus.mem_req_addr   = {r_addr[31:2], 2'b00};
    assign lsu_bus.mem_req_wdata  = r_req_wdata;
    assign lsu_bus.mem_req_wstrb  = r_req_wstrb;
    assign lsu_bus.mem_resp_ready = (r_state == S_WAIT_RESP);

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized self-checking bench for lsu against a behavioural model.
module tb_lsu;

    logic clk = 1'b0;
    logic rst;

    lsu_if bus();

    lsu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .lsu_bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] addr;
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rwen;
        logic [1:0]  sel;
        logic [31:0] csr;
    } op_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [108:0] pack(input op_t op);
        return {op.addr, op.ren, op.wen, op.f3, op.sdata, op.rd, op.rwen, op.sel, op.csr};
    endfunction

    function automatic logic m_misaligned(input op_t op);
`ifdef LSU_MISALIGN_CHECK_EN
        int off;
        off = int'(op.addr % 32'd4);
        if (!(op.ren || op.wen)) return 1'b0;
        if ((op.f3 == 3'd1 || op.f3 == 3'd5) && (off % 2 != 0)) return 1'b1;
        if (op.f3 == 3'd2 && off != 0) return 1'b1;
        return 1'b0;
`else
        return (op.addr == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdata, input int off, input logic [2:0] f3);
        logic [31:0] s;
        logic [31:0] v;
        s = rdata >> (8 * off);
        case (f3)
            3'd0: begin v = s % 32'd256;   if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
            3'd4: v = s % 32'd256;
            3'd1: begin v = s % 32'd65536; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
            3'd5: v = s % 32'd65536;
            default: v = s;
        endcase
        return v;
    endfunction

    task automatic run_op(input op_t op, input logic [31:0] rdata, input int req_dly,
                          input int resp_dly, input int wb_dly, input string nm);
        logic        is_mem;
        logic        mis;
        logic        exp_wen;
        logic        chk_wb;
        logic [31:0] exp_wb;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [127:0] junk;
        int          off;
        off       = int'(op.addr % 32'd4);
        is_mem    = op.ren | op.wen;
        mis       = m_misaligned(op);
        exp_wdata = op.sdata << (8 * off);
        exp_strb  = 4'd0;
        if (op.wen) begin
            if (op.f3 == 3'd0)      exp_strb = 4'(1 << off);
            else if (op.f3 == 3'd1) exp_strb = 4'((3 << off) % 16);
            else                    exp_strb = 4'd15;
        end
        exp_wb = 32'd0;
        chk_wb = 1'b1;
        if (mis) begin
            exp_wen = 1'b0; chk_wb = 1'b0;
        end else if (!is_mem) begin
            exp_wen = op.rwen;
            exp_wb  = (op.sel == 2'd0) ? op.addr : (op.sel == 2'd2) ? op.csr : 32'd0;
        end else if (op.wen) begin
            exp_wen = 1'b0; chk_wb = 1'b0;
        end else begin
            exp_wen = op.rwen;
            exp_wb  = m_load(rdata, off, op.f3);
        end

        @(negedge clk);
        check({nm, ".ready_idle"}, 64'(bus.lsu_ready), 64'(1'b1));
        bus.exu_valid = 1'b1;
        bus.exu_data  = pack(op);
        @(negedge clk);
        bus.exu_valid = 1'b0;
        junk = {$urandom, $urandom, $urandom, $urandom};
        bus.exu_data = junk[108:0];
        check({nm, ".ready_busy"}, 64'(bus.lsu_ready), 64'(1'b0));
        if (is_mem && !mis) begin
            for (int i = 0; i <= req_dly; i++) begin
                check({nm, ".req_valid"}, 64'(bus.mem_req_valid), 64'(1'b1));
                check({nm, ".req_addr"},  64'(bus.mem_req_addr), 64'({op.addr[31:2], 2'b00}));
                check({nm, ".req_wen"},   64'(bus.mem_req_wen), 64'(op.wen));
                check({nm, ".req_wstrb"}, 64'(bus.mem_req_wstrb), 64'(exp_strb));
                if (op.wen) check({nm, ".req_wdata"}, 64'(bus.mem_req_wdata), 64'(exp_wdata));
                check({nm, ".early_valid"}, 64'(bus.lsu_valid), 64'(1'b0));
                bus.mem_resp_rdata = ~rdata;
                if (i == req_dly) begin
                    bus.mem_req_ready  = 1'b1;
                    bus.mem_resp_valid = 1'b1;
                end else begin
                    bus.mem_resp_valid = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            for (int i = 0; i <= resp_dly; i++) begin
                check({nm, ".req_drop"},   64'(bus.mem_req_valid), 64'(1'b0));
                check({nm, ".resp_ready"}, 64'(bus.mem_resp_ready), 64'(1'b1));
                check({nm, ".wait_valid"}, 64'(bus.lsu_valid), 64'(1'b0));
                if (i == resp_dly) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_rdata = rdata;
                end
                @(negedge clk);
            end
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_rdata = $urandom;
        end else begin
            check({nm, ".no_req"}, 64'(bus.mem_req_valid), 64'(1'b0));
        end
        for (int i = 0; i <= wb_dly; i++) begin
            check({nm, ".valid"},    64'(bus.lsu_valid), 64'(1'b1));
            check({nm, ".ready_out"}, 64'(bus.lsu_ready), 64'(1'b0));
            check({nm, ".req_out"},  64'(bus.mem_req_valid), 64'(1'b0));
            check({nm, ".fault"},    64'(bus.lsu_fault), 64'(mis));
            check({nm, ".rd_wen"},   64'(bus.lsu_data[37:32]), 64'({op.rd, exp_wen}));
            if (chk_wb) check({nm, ".wb_data"}, 64'(bus.lsu_data[31:0]), 64'(exp_wb));
            if (i == wb_dly) bus.wbu_ready = 1'b1;
            @(negedge clk);
        end
        bus.wbu_ready = 1'b0;
        check({nm, ".one_bundle"}, 64'(bus.lsu_valid), 64'(1'b0));
        check({nm, ".ready_after"}, 64'(bus.lsu_ready), 64'(1'b1));
    endtask

    function automatic op_t mk(input logic [31:0] addr, input logic ren, input logic wen,
                               input logic [2:0] f3, input logic [31:0] sdata, input logic [4:0] rd,
                               input logic rwen, input logic [1:0] sel, input logic [31:0] csr);
        op_t o;
        o.addr = addr; o.ren = ren; o.wen = wen; o.f3 = f3; o.sdata = sdata;
        o.rd = rd; o.rwen = rwen; o.sel = sel; o.csr = csr;
        return o;
    endfunction

    initial begin
        op_t op;
        int  kind;
        rst = 1'b1;
        bus.exu_valid = 1'b0; bus.exu_data = '0; bus.wbu_ready = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst.ready",      64'(bus.lsu_ready), 64'(1'b1));
        check("rst.valid",      64'(bus.lsu_valid), 64'(1'b0));
        check("rst.req_valid",  64'(bus.mem_req_valid), 64'(1'b0));
        check("rst.resp_ready", 64'(bus.mem_resp_ready), 64'(1'b0));
        check("rst.fault",      64'(bus.lsu_fault), 64'(1'b0));
        check("rst.data",       64'(bus.lsu_data), 64'd0);
        rst = 1'b0;

        // Directed cases
        run_op(mk(32'h0000_1234, 1'b0, 1'b0, 3'd0, 32'd0, 5'd5, 1'b1, 2'd0, 32'd0), 32'd0, 0, 0, 0, "alu");
        run_op(mk(32'h1111_2222, 1'b0, 1'b0, 3'd0, 32'd0, 5'd6, 1'b1, 2'd1, 32'h5), 32'd0, 0, 0, 1, "sel_mem");
        run_op(mk(32'h1111_2222, 1'b0, 1'b0, 3'd0, 32'd0, 5'd7, 1'b1, 2'd2, 32'hCAFE_F00D), 32'd0, 0, 0, 0, "sel_csr");
        run_op(mk(32'h1111_2222, 1'b0, 1'b0, 3'd0, 32'd0, 5'd8, 1'b0, 2'd3, 32'h5), 32'd0, 0, 0, 0, "sel_zero");
        run_op(mk(32'h8000_0003, 1'b1, 1'b0, 3'd0, 32'd0, 5'd9, 1'b1, 2'd1, 32'd0), 32'h80FF_FFFF, 0, 0, 0, "lb");
        run_op(mk(32'h8000_0003, 1'b1, 1'b0, 3'd4, 32'd0, 5'd9, 1'b1, 2'd1, 32'd0), 32'h80FF_FFFF, 0, 0, 0, "lbu");
        run_op(mk(32'h8000_0002, 1'b0, 1'b1, 3'd1, 32'h0000_ABCD, 5'd3, 1'b1, 2'd0, 32'd0), 32'd0, 0, 0, 0, "sh");
        run_op(mk(32'h8000_0010, 1'b1, 1'b0, 3'd2, 32'd0, 5'd10, 1'b1, 2'd1, 32'd0), 32'h1234_5678, 3, 2, 4, "stall");
        run_op(mk(32'h8000_0001, 1'b1, 1'b1, 3'd0, 32'h0000_00EE, 5'd11, 1'b1, 2'd1, 32'd0), 32'd0, 1, 0, 0, "both");
        run_op(mk(32'h8000_0002, 1'b1, 1'b0, 3'd2, 32'd0, 5'd12, 1'b1, 2'd1, 32'd0), 32'hA5A5_5A5A, 0, 0, 0, "lw_mis");

        // Reset while waiting for a response
        @(negedge clk);
        bus.exu_valid = 1'b1;
        bus.exu_data  = pack(mk(32'h8000_0000, 1'b1, 1'b0, 3'd2, 32'd0, 5'd1, 1'b1, 2'd1, 32'd0));
        @(negedge clk);
        bus.exu_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check("rrst.in_wait", 64'(bus.mem_resp_ready), 64'(1'b1));
        rst = 1'b1;
        #1;
        check("rrst.ready",     64'(bus.lsu_ready), 64'(1'b1));
        check("rrst.req_valid", 64'(bus.mem_req_valid), 64'(1'b0));
        check("rrst.resp_rdy",  64'(bus.mem_resp_ready), 64'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        check("rrst.no_valid", 64'(bus.lsu_valid), 64'(1'b0));
        check("rrst.ready2",   64'(bus.lsu_ready), 64'(1'b1));
        @(negedge clk);
        check("rrst.no_valid2", 64'(bus.lsu_valid), 64'(1'b0));

        // Randomized operations
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 3));
            op = mk($urandom, 1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, 5'($urandom),
                    1'($urandom), 2'($urandom), $urandom);
            if (kind == 1) begin
                op.ren = 1'b1;
            end else if (kind >= 2) begin
                op.wen = 1'b1;
                op.ren = (kind == 3);
                op.f3  = 3'($urandom_range(0, 2));
            end
            run_op(op, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
